// File: rtl/exe_stage_pipe_if.sv
// Bus bundle for the execute stage: ID/EX inputs, forwarding sources,
// pipeline control and the registered EX/MEM outputs.
// The master side (upstream/testbench) drives the inputs; the slave side is the stage.
interface exe_stage_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic [3:0]        alu_code;
  logic              use_imm;
  logic [ADDR_W-1:0] pc_in;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W-1:0] imm;
  logic [REG_AW-1:0] a_reg;
  logic [REG_AW-1:0] b_reg;
  logic [REG_AW-1:0] dst_in;
  logic              regwrt_in;
  logic [1:0]        mem_ctl_in;
  logic [3:0]        br_mask;
  logic              mem_regwrt;
  logic              wb_regwrt;
  logic [REG_AW-1:0] mem_dest;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] wb_data;
  logic              stall_in;
  logic              flush;
  logic              hold_up;
  logic              out_valid;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [ADDR_W-1:0] target_addr;
  logic              zero;
  logic              carry;
  logic [3:0]        branch_taken;
  logic [1:0]        mem_ctl_out;
  logic [REG_AW-1:0] dst_out;
  logic              regwrt_out;

  modport master (
    output in_valid, alu_code, use_imm, pc_in, a_data, b_data, imm, a_reg, b_reg,
           dst_in, regwrt_in, mem_ctl_in, br_mask, mem_regwrt, wb_regwrt, mem_dest,
           wb_dest, mem_data, wb_data, stall_in, flush,
    input  hold_up, out_valid, alu_result, store_data, target_addr, zero, carry,
           branch_taken, mem_ctl_out, dst_out, regwrt_out
  );

  modport slave (
    input  in_valid, alu_code, use_imm, pc_in, a_data, b_data, imm, a_reg, b_reg,
           dst_in, regwrt_in, mem_ctl_in, br_mask, mem_regwrt, wb_regwrt, mem_dest,
           wb_dest, mem_data, wb_data, stall_in, flush,
    output hold_up, out_valid, alu_result, store_data, target_addr, zero, carry,
           branch_taken, mem_ctl_out, dst_out, regwrt_out
  );
endinterface

// File: rtl/exe_stage_pipe.sv
// Execute stage with operand forwarding, ALU, branch evaluation and its own
// EX/MEM output register. Every output is registered except hold_up.
// Optional multi-cycle shift-add multiplier (alu_code 8) is built only when
// the macro EXE_MUL_EN is defined; otherwise code 8 yields 0 in one cycle.
module exe_stage_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int REG_AW = 4
) (
  input logic            clk,
  input logic            rst,
  exe_stage_pipe_if.slave bus
);

  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              alu_zero;
  logic [ADDR_W-1:0] imm_addr;
  logic [ADDR_W-1:0] target;

  logic              n_valid;
  logic [DATA_W-1:0] n_result;
  logic              n_zero;
  logic              n_carry;
  logic [DATA_W-1:0] n_store;
  logic [ADDR_W-1:0] n_target;
  logic [1:0]        n_mem;
  logic [REG_AW-1:0] n_dst;
  logic              n_rw;
  logic [3:0]        n_mask;
  logic [3:0]        n_branch;

  // Branch offset is the immediate resized to the address width (sign-extended when narrower)
  generate
    if (DATA_W >= ADDR_W) begin : g_imm_trunc
      assign imm_addr = bus.imm[ADDR_W-1:0];
    end else begin : g_imm_sext
      assign imm_addr = {{(ADDR_W-DATA_W){bus.imm[DATA_W-1]}}, bus.imm};
    end
  endgenerate

  assign target = bus.pc_in + imm_addr;

  // Pick the freshest value of each source: MEM beats WB beats register file
  always_comb begin
    fwd_a = bus.a_data;
    if (bus.mem_regwrt && bus.mem_dest == bus.a_reg) fwd_a = bus.mem_data;
    else if (bus.wb_regwrt && bus.wb_dest == bus.a_reg) fwd_a = bus.wb_data;
    fwd_b = bus.b_data;
    if (bus.mem_regwrt && bus.mem_dest == bus.b_reg) fwd_b = bus.mem_data;
    else if (bus.wb_regwrt && bus.wb_dest == bus.b_reg) fwd_b = bus.wb_data;
    op_b = bus.use_imm ? bus.imm : fwd_b;
  end

  // Single-cycle ALU; carry only comes out of add/sub
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.alu_code)
      4'd0: begin
        sum       = {1'b0, fwd_a} + {1'b0, op_b};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      4'd1: begin
        sum       = {1'b0, fwd_a} + {1'b0, ~op_b} + ONE;
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      4'd2:    alu_res = fwd_a & op_b;
      4'd3:    alu_res = fwd_a | op_b;
      4'd4:    alu_res = fwd_a ^ op_b;
      4'd5:    alu_res = ~fwd_a;
      4'd6:    alu_res = {fwd_a[DATA_W-2:0], 1'b0};
      4'd7:    alu_res = {1'b0, fwd_a[DATA_W-1:1]};
      4'd9:    alu_res = op_b;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

`ifdef EXE_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] l_store;
  logic [ADDR_W-1:0] l_target;
  logic [REG_AW-1:0] l_dst;
  logic              l_rw;
  logic [1:0]        l_mem;
  logic [3:0]        l_mask;
  logic              mul_start;

  assign mul_start   = (state == IDLE) && bus.in_valid && (bus.alu_code == 4'd8);
  assign bus.hold_up = bus.stall_in || (state == MUL) || mul_start;

  // Multiplier sequencer: latch operands, one shift-add step per cycle, then wait to retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      acc      <= '0;
      l_store  <= '0;
      l_target <= '0;
      l_dst    <= '0;
      l_rw     <= 1'b0;
      l_mem    <= '0;
      l_mask   <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            mul_a    <= fwd_a;
            mul_b    <= op_b;
            acc      <= '0;
            cnt      <= '0;
            l_store  <= fwd_b;
            l_target <= target;
            l_dst    <= bus.dst_in;
            l_rw     <= bus.regwrt_in;
            l_mem    <= bus.mem_ctl_in;
            l_mask   <= bus.br_mask;
            state    <= MUL;
          end
        end
        MUL: begin
          if (mul_b[0]) acc <= acc + mul_a;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (!bus.stall_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign bus.hold_up = bus.stall_in;
`endif

  // Choose what the EX/MEM register captures next: ALU result, finished product or a bubble
  always_comb begin
    n_valid  = bus.in_valid && !bus.flush;
    n_result = alu_res;
    n_zero   = alu_zero;
    n_carry  = alu_carry;
    n_store  = fwd_b;
    n_target = target;
    n_mem    = bus.mem_ctl_in;
    n_dst    = bus.dst_in;
    n_rw     = bus.regwrt_in;
    n_mask   = bus.br_mask;
`ifdef EXE_MUL_EN
    if (state == DONE) begin
      n_valid  = !bus.flush;
      n_result = acc;
      n_zero   = (acc == '0);
      n_carry  = 1'b0;
      n_store  = l_store;
      n_target = l_target;
      n_mem    = l_mem;
      n_dst    = l_dst;
      n_rw     = l_rw;
      n_mask   = l_mask;
    end else if (state == MUL || mul_start) begin
      n_valid = 1'b0;
    end
`endif
    n_branch = {n_mask[3] & n_zero, n_mask[2] & ~n_zero,
                n_mask[1] & n_carry, n_mask[0] & ~n_carry};
    if (!n_valid) begin
      n_rw     = 1'b0;
      n_mem    = '0;
      n_branch = '0;
    end
  end

  // EX/MEM register: holds on downstream stall, otherwise captures the selected values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.alu_result   <= '0;
      bus.store_data   <= '0;
      bus.target_addr  <= '0;
      bus.zero         <= 1'b0;
      bus.carry        <= 1'b0;
      bus.branch_taken <= '0;
      bus.mem_ctl_out  <= '0;
      bus.dst_out      <= '0;
      bus.regwrt_out   <= 1'b0;
    end else if (!bus.stall_in) begin
      bus.out_valid    <= n_valid;
      bus.alu_result   <= n_result;
      bus.store_data   <= n_store;
      bus.target_addr  <= n_target;
      bus.zero         <= n_zero;
      bus.carry        <= n_carry;
      bus.branch_taken <= n_branch;
      bus.mem_ctl_out  <= n_mem;
      bus.dst_out      <= n_dst;
      bus.regwrt_out   <= n_rw;
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed testbench for exe_stage_pipe (DATA_W=8, ADDR_W=8, REG_AW=4).
// Multiplier scenarios are exercised when EXE_MUL_EN is defined; otherwise
// code 8 is checked as an undefined single-cycle operation.
module tb_exe_stage_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exe_stage_pipe_if #(.DATA_W(8), .ADDR_W(8), .REG_AW(4)) bus ();

  exe_stage_pipe #(.DATA_W(8), .ADDR_W(8), .REG_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] code;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       cy;
  } vec_t;

  vec_t vecs[10];

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b,
                               input logic uimm, input logic [7:0] immv);
    bus.in_valid = 1'b1;
    bus.alu_code = code;
    bus.a_data   = a;
    bus.b_data   = b;
    bus.use_imm  = uimm;
    bus.imm      = immv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;   bus.alu_code = '0;   bus.use_imm = 1'b0;  bus.pc_in = '0;
    bus.a_data = '0;       bus.b_data = '0;     bus.imm = '0;        bus.a_reg = 4'd1;
    bus.b_reg = 4'd3;      bus.dst_in = '0;     bus.regwrt_in = 1'b0; bus.mem_ctl_in = '0;
    bus.br_mask = '0;      bus.mem_regwrt = 1'b0; bus.wb_regwrt = 1'b0; bus.mem_dest = '0;
    bus.wb_dest = '0;      bus.mem_data = '0;   bus.wb_data = '0;    bus.stall_in = 1'b0;
    bus.flush = 1'b0;
    #12;
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_hold_up", {31'd0, bus.hold_up}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Forwarding priority on source A
    bus.a_reg = 4'd2; bus.b_reg = 4'd3;
    bus.mem_regwrt = 1'b1; bus.mem_dest = 4'd2; bus.mem_data = 8'h11;
    bus.wb_regwrt = 1'b1;  bus.wb_dest = 4'd2;  bus.wb_data = 8'h22;
    bus.dst_in = 4'd7; bus.regwrt_in = 1'b1;
    applyStimulus(4'd0, 8'h55, 8'h01, 1'b0, 8'h00);
    tick();
    checkOutput("fwd_mem_result", {24'd0, bus.alu_result}, 32'h12);
    checkOutput("fwd_out_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("fwd_store_data", {24'd0, bus.store_data}, 32'h01);
    checkOutput("fwd_dst_out", {28'd0, bus.dst_out}, 32'd7);
    checkOutput("fwd_regwrt_out", {31'd0, bus.regwrt_out}, 32'd1);
    bus.mem_regwrt = 1'b0;
    tick();
    checkOutput("fwd_wb_result", {24'd0, bus.alu_result}, 32'h23);
    bus.wb_regwrt = 1'b0;
    tick();
    checkOutput("fwd_rf_result", {24'd0, bus.alu_result}, 32'h56);
    // Forwarding on source B reaches store_data and the ALU
    bus.b_reg = 4'd4; bus.mem_regwrt = 1'b1; bus.mem_dest = 4'd4; bus.mem_data = 8'h30;
    applyStimulus(4'd0, 8'h01, 8'h99, 1'b0, 8'h00);
    tick();
    checkOutput("fwd_b_result", {24'd0, bus.alu_result}, 32'h31);
    checkOutput("fwd_b_store", {24'd0, bus.store_data}, 32'h30);
    bus.mem_regwrt = 1'b0; bus.b_reg = 4'd3; bus.a_reg = 4'd1;

    // Carry and branch evaluation
    bus.br_mask = 4'b1010;
    applyStimulus(4'd0, 8'hFF, 8'h01, 1'b0, 8'h00);
    tick();
    checkOutput("carry_result", {24'd0, bus.alu_result}, 32'h00);
    checkOutput("carry_zero", {31'd0, bus.zero}, 32'd1);
    checkOutput("carry_carry", {31'd0, bus.carry}, 32'd1);
    checkOutput("carry_branch", {28'd0, bus.branch_taken}, 32'hA);
    bus.br_mask = 4'b0101;
    applyStimulus(4'd0, 8'h01, 8'h01, 1'b0, 8'h00);
    tick();
    checkOutput("nz_branch", {28'd0, bus.branch_taken}, 32'h5);

    // Subtract to zero and target wrap
    bus.br_mask = 4'b0000; bus.pc_in = 8'hFE;
    applyStimulus(4'd1, 8'h05, 8'h05, 1'b0, 8'h03);
    tick();
    checkOutput("sub_zero", {31'd0, bus.zero}, 32'd1);
    checkOutput("sub_carry", {31'd0, bus.carry}, 32'd1);
    checkOutput("sub_target", {24'd0, bus.target_addr}, 32'h01);

    // Immediate operand replaces B in the ALU but not in store_data
    bus.pc_in = 8'h10;
    applyStimulus(4'd0, 8'h10, 8'h40, 1'b1, 8'h03);
    tick();
    checkOutput("imm_result", {24'd0, bus.alu_result}, 32'h13);
    checkOutput("imm_store", {24'd0, bus.store_data}, 32'h40);
    checkOutput("imm_target", {24'd0, bus.target_addr}, 32'h13);

    // Remaining ALU codes
    vecs[0] = '{4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1] = '{4'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0};
    vecs[2] = '{4'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0};
    vecs[3] = '{4'd5, 8'h0F, 8'h00, 8'hF0, 1'b0};
    vecs[4] = '{4'd6, 8'h81, 8'h00, 8'h02, 1'b0};
    vecs[5] = '{4'd7, 8'h81, 8'h00, 8'h40, 1'b0};
    vecs[6] = '{4'd9, 8'h11, 8'h5A, 8'h5A, 1'b0};
    vecs[7] = '{4'd15, 8'h11, 8'h22, 8'h00, 1'b0};
    vecs[8] = '{4'd0, 8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[9] = '{4'd1, 8'h03, 8'h05, 8'hFE, 1'b0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].code, vecs[i].a, vecs[i].b, 1'b0, 8'h00);
      tick();
      checkOutput($sformatf("alu_code%0d_result", vecs[i].code), {24'd0, bus.alu_result}, {24'd0, vecs[i].res});
      checkOutput($sformatf("alu_code%0d_carry", vecs[i].code), {31'd0, bus.carry}, {31'd0, vecs[i].cy});
      checkOutput($sformatf("alu_code%0d_zero", vecs[i].code), {31'd0, bus.zero}, {31'd0, (vecs[i].res == 8'h00)});
    end

    // Bubble clears control outputs
    bus.regwrt_in = 1'b1; bus.mem_ctl_in = 2'b11; bus.br_mask = 4'hF;
    applyStimulus(4'd0, 8'h00, 8'h00, 1'b0, 8'h00);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("bubble_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("bubble_regwrt", {31'd0, bus.regwrt_out}, 32'd0);
    checkOutput("bubble_memctl", {30'd0, bus.mem_ctl_out}, 32'd0);
    checkOutput("bubble_branch", {28'd0, bus.branch_taken}, 32'd0);

    // Live instruction pipes its memory controls
    bus.br_mask = 4'h0; bus.mem_ctl_in = 2'b10;
    applyStimulus(4'd0, 8'h01, 8'h02, 1'b0, 8'h00);
    tick();
    checkOutput("live_memctl", {30'd0, bus.mem_ctl_out}, 32'd2);

    // Downstream stall holds the EX/MEM register
    bus.stall_in = 1'b1;
    applyStimulus(4'd0, 8'h09, 8'h09, 1'b0, 8'h00);
    checkOutput("stall_hold_up", {31'd0, bus.hold_up}, 32'd1);
    tick();
    checkOutput("stall_result_held", {24'd0, bus.alu_result}, 32'h03);
    bus.stall_in = 1'b0;
    #1;
    checkOutput("unstall_hold_up", {31'd0, bus.hold_up}, 32'd0);
    tick();
    checkOutput("unstall_result", {24'd0, bus.alu_result}, 32'h12);

    // Flush kills the instruction
    bus.flush = 1'b1;
    applyStimulus(4'd0, 8'h01, 8'h01, 1'b0, 8'h00);
    tick();
    checkOutput("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("flush_regwrt", {31'd0, bus.regwrt_out}, 32'd0);
    bus.flush = 1'b0;

`ifdef EXE_MUL_EN
    // 13 * 11: hold_up for 9 cycles, product after the 10th edge
    bus.dst_in = 4'd9;
    applyStimulus(4'd8, 8'd13, 8'd11, 1'b0, 8'h00);
    checkOutput("mul_hold_present", {31'd0, bus.hold_up}, 32'd1);
    for (int e = 1; e <= 9; e++) begin
      tick();
      checkOutput($sformatf("mul_hold_edge%0d", e), {31'd0, bus.hold_up}, {31'd0, (e < 9)});
      checkOutput($sformatf("mul_valid_edge%0d", e), {31'd0, bus.out_valid}, 32'd0);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checkOutput("mul_result", {24'd0, bus.alu_result}, 32'h8F);
    checkOutput("mul_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("mul_carry", {31'd0, bus.carry}, 32'd0);
    checkOutput("mul_dst", {28'd0, bus.dst_out}, 32'd9);
    checkOutput("mul_hold_after", {31'd0, bus.hold_up}, 32'd0);

    // Multiply stalled in DONE for 3 cycles
    applyStimulus(4'd8, 8'd3, 8'd5, 1'b0, 8'h00);
    for (int e = 0; e < 9; e++) tick();
    bus.stall_in = 1'b1;
    for (int e = 0; e < 3; e++) begin
      #1;
      checkOutput($sformatf("mulstall_hold%0d", e), {31'd0, bus.hold_up}, 32'd1);
      tick();
      checkOutput($sformatf("mulstall_valid%0d", e), {31'd0, bus.out_valid}, 32'd0);
    end
    bus.stall_in = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checkOutput("mulstall_result", {24'd0, bus.alu_result}, 32'h0F);
    checkOutput("mulstall_valid", {31'd0, bus.out_valid}, 32'd1);

    // Flush during MUL aborts
    applyStimulus(4'd8, 8'd6, 8'd6, 1'b0, 8'h00);
    for (int e = 0; e < 3; e++) tick();
    bus.flush = 1'b1; bus.in_valid = 1'b0;
    tick();
    bus.flush = 1'b0;
    #1;
    checkOutput("mulflush_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("mulflush_hold", {31'd0, bus.hold_up}, 32'd0);
    applyStimulus(4'd0, 8'h01, 8'h01, 1'b0, 8'h00);
    tick();
    checkOutput("mulflush_next", {24'd0, bus.alu_result}, 32'h02);
    checkOutput("mulflush_next_valid", {31'd0, bus.out_valid}, 32'd1);
`else
    // Without the multiplier, code 8 is a single-cycle zero result
    applyStimulus(4'd8, 8'd13, 8'd11, 1'b0, 8'h00);
    checkOutput("code8_hold", {31'd0, bus.hold_up}, 32'd0);
    tick();
    checkOutput("code8_result", {24'd0, bus.alu_result}, 32'h00);
    checkOutput("code8_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("code8_zero", {31'd0, bus.zero}, 32'd1);
`endif

    // Asynchronous reset in the middle of a (multiply) operation
    bus.dst_in = 4'd5;
    applyStimulus(4'd0, 8'h10, 8'h20, 1'b0, 8'h00);
    tick();
    checkOutput("prereset_result", {24'd0, bus.alu_result}, 32'h30);
    applyStimulus(4'd8, 8'd7, 8'd3, 1'b0, 8'h00);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_result", {24'd0, bus.alu_result}, 32'd0);
    checkOutput("rst_dst", {28'd0, bus.dst_out}, 32'd0);
    checkOutput("rst_store", {24'd0, bus.store_data}, 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_hold_up", {31'd0, bus.hold_up}, 32'd0);
    applyStimulus(4'd0, 8'h02, 8'h03, 1'b0, 8'h00);
    tick();
    checkOutput("postrst_result", {24'd0, bus.alu_result}, 32'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
